// File: rtl/board_input_capture.sv
// Button/switch input front end: synchronizes switches, debounces six buttons into
// one-cycle press strobes, and captures shift operands in the single clk domain.
module board_input_capture #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:32]  sw,
  input  logic [1:6]   swb,
  output logic [32:1]  shift_data,
  output logic [8:1]   shift_num,
  output logic [3:1]   shift_op,
  output logic         carry_flag,
  output logic [1:6]   btn_pulse,
  output logic         load_valid
);

  typedef enum logic [1:0] {
    RELEASED,
    CHECK_PRESS,
    PRESSED,
    CHECK_RELEASE
  } btn_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:32] sw_meta_reg, sw_s;
  logic [1:6]  swb_meta_reg, swb_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_reg  <= '0;
      sw_s         <= '0;
      swb_meta_reg <= '0;
      swb_s        <= '0;
    end else begin
      sw_meta_reg  <= sw;
      sw_s         <= sw_meta_reg;
      swb_meta_reg <= swb;
      swb_s        <= swb_meta_reg;
    end
  end

  // One debounce FSM per button; the strobe fires only on the CHECK_PRESS -> PRESSED step.
  for (genvar gi = 1; gi <= 6; gi++) begin : g_btn
    btn_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pulse_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_reg <= RELEASED;
        cnt_reg   <= '0;
        pulse_reg <= 1'b0;
      end else begin
        pulse_reg <= 1'b0;
        case (state_reg)
          RELEASED: begin
            if (swb_s[gi]) begin
              state_reg <= CHECK_PRESS;
              cnt_reg   <= CNT_ONE;
            end
          end
          CHECK_PRESS: begin
            if (!swb_s[gi]) begin
              state_reg <= RELEASED;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg <= PRESSED;
              cnt_reg   <= '0;
              pulse_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!swb_s[gi]) begin
              state_reg <= CHECK_RELEASE;
              cnt_reg   <= CNT_ONE;
            end
          end
          CHECK_RELEASE: begin
            if (swb_s[gi]) begin
              state_reg <= PRESSED;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg <= RELEASED;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_reg <= RELEASED;
            cnt_reg   <= '0;
          end
        endcase
      end
    end

    assign btn_pulse[gi] = pulse_reg;
  end

  // Buttons 3..5 are strobe-only, so they never raise load_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_data <= '0;
      shift_num  <= '0;
      shift_op   <= '0;
      carry_flag <= 1'b0;
      load_valid <= 1'b0;
    end else begin
      load_valid <= btn_pulse[1] | btn_pulse[2] | btn_pulse[6];
      if (btn_pulse[1]) shift_data <= sw_s;
      if (btn_pulse[2]) {shift_num, shift_op} <= sw_s[1:11];
      if (btn_pulse[6]) carry_flag <= ~carry_flag;
    end
  end

endmodule

// File: tb/tb_board_input_capture.sv
// Bench for board_input_capture: vector table plus hand sequences, with a
// scoreboard queue checked whenever load_valid fires.
module tb_board_input_capture;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:32] sw;
  logic [1:6]  swb;
  logic [32:1] shift_data;
  logic [8:1]  shift_num;
  logic [3:1]  shift_op;
  logic        carry_flag;
  logic [1:6]  btn_pulse;
  logic        load_valid;

  board_input_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .swb        (swb),
    .shift_data (shift_data),
    .shift_num  (shift_num),
    .shift_op   (shift_op),
    .carry_flag (carry_flag),
    .btn_pulse  (btn_pulse),
    .load_valid (load_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  num;
    logic [2:0]  op;
    logic        carry;
  } exp_t;

  typedef struct {
    logic [1:6]  buttons;
    logic [31:0] swv;
    logic        loads;
    exp_t        expv;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req)
      $display("FAIL %s: got %h expected %h", name, act, req);
    else
      passes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (btn_pulse == 6'b0 && n < 30);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (load_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_load_valid", 32'(load_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("shift_data", 32'(shift_data), e.data);
        check("shift_num",  32'(shift_num),  32'(e.num));
        check("shift_op",   32'(shift_op),   32'(e.op));
        check("carry_flag", 32'(carry_flag), 32'(e.carry));
        $display("load: data=%h num=%h op=%b carry=%b", shift_data, shift_num, shift_op, carry_flag);
      end
    end
  end

  task automatic release_idle(input string name);
    logic [1:6] seen;
    seen = '0;
    swb = '0;
    repeat (D + 4) begin
      tick();
      seen |= btn_pulse;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    vec_t vecs[9];
    int   n;
    int   cnt6;

    vecs[0] = '{6'b100000, 32'hDEADBEEF, 1'b1, '{32'hDEADBEEF, 8'h00, 3'd0, 1'b0}};
    vecs[1] = '{6'b010000, 32'h05600000, 1'b1, '{32'hDEADBEEF, 8'h05, 3'b011, 1'b0}};
    vecs[2] = '{6'b000001, 32'h00000000, 1'b1, '{32'hDEADBEEF, 8'h05, 3'b011, 1'b1}};
    vecs[3] = '{6'b001000, 32'hFFFFFFFF, 1'b0, '{32'hDEADBEEF, 8'h05, 3'b011, 1'b1}};
    vecs[4] = '{6'b110000, 32'h12345678, 1'b1, '{32'h12345678, 8'h12, 3'b001, 1'b1}};
    vecs[5] = '{6'b000001, 32'h00000000, 1'b1, '{32'h12345678, 8'h12, 3'b001, 1'b0}};
    vecs[6] = '{6'b000001, 32'h00000000, 1'b1, '{32'h12345678, 8'h12, 3'b001, 1'b1}};
    vecs[7] = '{6'b000110, 32'h00000000, 1'b0, '{32'h12345678, 8'h12, 3'b001, 1'b1}};
    vecs[8] = '{6'b110001, 32'hA5A5A5A5, 1'b1, '{32'hA5A5A5A5, 8'hA5, 3'b101, 1'b0}};

    // Reset with every input asserted
    rst = 1'b1;
    swb = 6'b111111;
    sw  = 32'hFFFFFFFF;
    repeat (3) tick();
    check("rst_data",  32'(shift_data), 32'd0);
    check("rst_num",   32'(shift_num),  32'd0);
    check("rst_op",    32'(shift_op),   32'd0);
    check("rst_carry", 32'(carry_flag), 32'd0);
    check("rst_pulse", 32'(btn_pulse),  32'd0);
    check("rst_load",  32'(load_valid), 32'd0);
    sb_q.push_back('{32'hFFFFFFFF, 8'hFF, 3'b111, 1'b1});
    rst = 1'b0;
    wait_pulse(n);
    $display("reset release: latency=%0d pulse=%b", n, btn_pulse);
    check("rst_held_latency", 32'(n), 32'(D + 2));
    check("rst_held_pulse", 32'(btn_pulse), 32'(6'b111111));
    tick();
    check("rst_held_load", 32'(load_valid), 32'd1);
    release_idle("rst_release_no_pulse");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Table-driven presses
    for (int i = 0; i < 9; i++) begin
      sw = vecs[i].swv;
      tick();
      tick();
      swb = vecs[i].buttons;
      if (vecs[i].loads) sb_q.push_back(vecs[i].expv);
      wait_pulse(n);
      $display("vec %0d: buttons=%b sw=%h latency=%0d pulse=%b", i, vecs[i].buttons, vecs[i].swv, n, btn_pulse);
      check("vec_latency", 32'(n), 32'(D + 2));
      check("vec_pulse", 32'(btn_pulse), 32'(vecs[i].buttons));
      tick();
      check("vec_pulse_one_cycle", 32'(btn_pulse), 32'd0);
      check("vec_load_valid", 32'(load_valid), 32'(vecs[i].loads));
      release_idle("vec_release_no_pulse");
    end

    // Bounce rejection on button 2
    sw = 32'h05600000;
    tick();
    n = 0;
    for (int k = 0; k < 4; k++) begin
      swb = (k % 2 == 0) ? 6'b010000 : 6'b000000;
      tick();
      if (btn_pulse != 0) n++;
    end
    check("bounce_no_pulse", 32'(n), 32'd0);
    swb = 6'b010000;
    sb_q.push_back('{32'hA5A5A5A5, 8'h05, 3'b011, 1'b0});
    wait_pulse(n);
    $display("bounce: latency=%0d pulse=%b", n, btn_pulse);
    check("bounce_latency", 32'(n), 32'(D + 2));
    check("bounce_pulse", 32'(btn_pulse), 32'(6'b010000));
    tick();
    release_idle("bounce_release_no_pulse");

    // Hold button 6 for 100 cycles, with a release shorter than the debounce window
    swb = 6'b000001;
    sb_q.push_back('{32'hA5A5A5A5, 8'h05, 3'b011, 1'b1});
    wait_pulse(n);
    check("hold_latency", 32'(n), 32'(D + 2));
    cnt6 = (btn_pulse[6] == 1'b1) ? 1 : 0;
    for (int k = 0; k < 100; k++) begin
      if (k == 50) swb = 6'b000000;
      if (k == 52) swb = 6'b000001;
      tick();
      if (btn_pulse[6]) cnt6++;
    end
    $display("hold: pulses=%0d carry=%b", cnt6, carry_flag);
    check("hold_single_pulse", 32'(cnt6), 32'd1);
    check("hold_carry", 32'(carry_flag), 32'd1);
    release_idle("hold_release_no_pulse");

    // Reset while button 1 is mid-debounce
    sw = 32'hCAFEF00D;
    tick();
    tick();
    swb = 6'b100000;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_data_async", 32'(shift_data), 32'd0);
    check("midrst_carry_async", 32'(carry_flag), 32'd0);
    check("midrst_pulse", 32'(btn_pulse), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    sb_q.push_back('{32'hCAFEF00D, 8'h00, 3'd0, 1'b0});
    wait_pulse(n);
    $display("mid-debounce reset: latency=%0d pulse=%b", n, btn_pulse);
    check("midrst_latency", 32'(n), 32'(D + 2));
    check("midrst_data_before", 32'(shift_data), 32'd0);
    tick();
    release_idle("midrst_release_no_pulse");

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/board_input_capture.md
# board_input_capture

Synchronous input front end for the FPGA board wrapper. It synchronizes and debounces the six push buttons, and synchronizes the 32 slide switches, in the `clk` domain. It emits one-cycle press strobes and captures the shift operands (`shift_data`, `shift_num`, `shift_op`) and the toggled `carry_flag` in registers clocked by `clk`. It is the input-side counterpart of the display driver and replaces button-edge-clocked operand registers, so everything downstream sits in the single `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive synchronized samples required to accept a button level change; legal range ≥ 2.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk`  in  1  board clock; sole clock of the block.
- `rst`  in  1  reset, asynchronous, active-high.
- `sw`  in  [1:32]  raw slide switches; `sw[1]` is the most significant bit.
- `swb`  in  [1:6]  raw push buttons; a pressed button reads 1.
- `shift_data`  out  [32:1]  captured shift operand.
- `shift_num`  out  [8:1]  captured shift amount.
- `shift_op`  out  [3:1]  captured shift opcode.
- `carry_flag`  out  1  carry-in flag, toggled by button 6.
- `btn_pulse`  out  [1:6]  one-cycle strobe per accepted press.
- `load_valid`  out  1  one-cycle strobe, high in the cycle after any of `shift_data`, `shift_num`, `shift_op` or `carry_flag` changes register value or is reloaded.

## Operation
- **Synchronizers:** each `sw` and `swb` bit passes through a 2-flop synchronizer (`sw_s`, `swb_s`). Switches are not debounced.
- **Button FSM:** each button has an independent FSM and counter with states RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE.
  - RELEASED: if `swb_s`=1, go to CHECK_PRESS with cnt=1; otherwise stay.
  - CHECK_PRESS: if `swb_s`=0, return to RELEASED with cnt=0. If `swb_s`=1 and cnt=DEBOUNCE_CYCLES−1, go to PRESSED. Otherwise cnt+1.
  - PRESSED: if `swb_s`=0, go to CHECK_RELEASE with cnt=1.
  - CHECK_RELEASE: this is the mirror of CHECK_PRESS. It returns to PRESSED on `swb_s`=1 and goes to RELEASED after DEBOUNCE_CYCLES consecutive 0 samples.
- **btn_pulse:** `btn_pulse[i]` is a register. It is high for exactly the first cycle that FSM i spends in PRESSED. Release generates no strobe.
- **Actions,** taken on the edge that ends a pulse cycle, using `sw_s` at that edge:
  - `btn_pulse[1]`: `shift_data` ← `sw_s[1:32]`.
  - `btn_pulse[2]`: {`shift_num`, `shift_op`} ← `sw_s[1:11]`, so `shift_num`=`sw_s[1:8]` and `shift_op`=`sw_s[9:11]`.
  - `btn_pulse[6]`: `carry_flag` ← ~`carry_flag`.
  - `btn_pulse[3:5]`: strobe only, no register action.
- **load_valid:** high for one cycle after any action edge.
- **Simultaneous pulses:** all actions apply on the same edge and `load_valid` pulses once.
- **Reset values:** all outputs 0. All FSMs RELEASED, all counters 0, all synchronizer flops 0.

## Timing
- **Press latency:** a raw press stable before edge 0 has `swb_s`=1 after edge 1. The FSM is sampled 1 at edges 2 … DEBOUNCE_CYCLES+1 and enters PRESSED at edge DEBOUNCE_CYCLES+1. `btn_pulse` is high from edge DEBOUNCE_CYCLES+1 to edge DEBOUNCE_CYCLES+2. The operand register updates at edge DEBOUNCE_CYCLES+2, and `load_valid` is high for the following cycle.
- **Minimum release:** a button must be released for DEBOUNCE_CYCLES consecutive samples before it can produce a new pulse.
- **Switch timing:** a switch change must be stable for 2 edges before the action edge to be captured.
- **Holding a button:** one pulse only; no auto-repeat.
- **Reset mid-debounce:** `rst` asserted at any time clears state immediately (asynchronously), including any in-flight pulse. After `rst` deasserts, a still-held button is treated as a new press and needs the full latency.
- **Counter width:** the counter never exceeds DEBOUNCE_CYCLES−1; no wrap.

## Test plan
- **Reset.** Stimulus: `rst`=1 with `swb`=6'b111111 and `sw`=all ones. Required: all outputs 0 during reset. After release, with buttons still held, `btn_pulse` all pulse at edge DEBOUNCE_CYCLES+2 after deassert. Using DEBOUNCE_CYCLES=4:
  - `shift_data`=32'hFFFFFFFF
  - `shift_num`=8'hFF
  - `shift_op`=3'b111
  - `carry_flag`=1
- **Clean press.** Setup: DEBOUNCE_CYCLES=4, `sw`=32'hDEADBEEF. Stimulus: press `swb[1]` before edge 0. Required: `btn_pulse[1]` high exactly from edge 5 to edge 6, `shift_data`=32'hDEADBEEF after edge 6, `load_valid` high for one cycle.
- **Bounce rejection.** Stimulus: `swb[2]` toggles 1,0,1,0 every cycle, then stays 1. Required: no pulse during bouncing; exactly one pulse after 4 stable samples. With `sw[1:11]`=11'b00000101011: `shift_num`=8'h05, `shift_op`=3'b011.
- **Toggle.** Stimulus: three separated presses of `swb[6]`. Required: `carry_flag` sequence 1, 0, 1. Holding the button for 100 cycles produces one toggle.
- **Simultaneous.** Stimulus: press `swb[1]` and `swb[2]` in the same cycle. Required: both registers update on the same edge and `load_valid` pulses once.
- **Reset mid-debounce.** Stimulus: assert `rst` while `swb[1]` is in CHECK_PRESS. Required: no pulse and `shift_data` stays 0. After release, the full latency restarts.
